ysyx_24100012_lsu: RTL and testbench

//  Load/store unit downstream of the instruction decoder. Consumes MemREn/MemWEn/func3 plus the ALU

---
 rtl/ysyx_24100012_lsu.sv | 217 +++++++++++++++++++++
 tb/tb_ysyx_24100012_lsu.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_lsu.sv
// Load/store unit: one word-aligned req/resp bus transaction per access, with byte/half lane
// steering and load extension. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses.
module ysyx_24100012_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_valid,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [2:0]            func3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  lsu_ready,
    output logic                  lsu_done,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_err,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_wstrb,
    input  logic                  bus_resp_valid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
    localparam logic       TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_we;
    logic [2:0]            r_func3;
    logic [1:0]            r_addr_lo;
    logic [7:0]            r_wait_cnt;
    logic                  r_lsu_ready;
    logic                  r_lsu_done;
    logic                  r_lsu_err;
    logic [DATA_WIDTH-1:0] r_lsu_rdata;
    logic                  r_bus_req_valid;
    logic                  r_bus_we;
    logic [DATA_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic [3:0]            r_bus_wstrb;

    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_resp_take;
    logic                  w_timeout;
    logic [7:0]            w_cnt_inc;
    logic [3:0]            w_st_strb;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [1:0]            w_ld_lane;
    logic [DATA_WIDTH-1:0] w_ld_shift;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_accept    = lsu_valid & (mem_ren | mem_wen);
    assign w_resp_take = (r_state == S_WAIT) & bus_resp_valid;
    assign w_cnt_inc   = r_wait_cnt + 8'd1;
    assign w_timeout   = (r_state == S_WAIT) & ~bus_resp_valid & TIMEOUT_EN
                         & (w_cnt_inc == TIMEOUT_LIM);

`ifdef LSU_MISALIGN_TRAP_EN
    // func3[1:0] of 10/11 is a word access; 01 is a half.
    assign w_misalign = ((func3[1:0] == 2'b01) & addr[0])
                      | (func3[1] & (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Store lane steering from the live request, latched at accept.
    always_comb begin
        w_st_strb = 4'b1111;
        w_st_data = wdata;
        case (func3[1:0])
            2'b00: begin
                w_st_strb = 4'b0001 << addr[1:0];
                w_st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_st_strb = 4'b0011 << {addr[1], 1'b0};
                w_st_data = {2{wdata[15:0]}};
            end
            default: begin
                w_st_strb = 4'b1111;
                w_st_data = wdata;
            end
        endcase
    end

    // Load lane select and extension from the latched access attributes.
    always_comb begin
        w_ld_lane = 2'b00;
        case (r_func3[1:0])
            2'b00:   w_ld_lane = r_addr_lo;
            2'b01:   w_ld_lane = {r_addr_lo[1], 1'b0};
            default: w_ld_lane = 2'b00;
        endcase
        w_ld_shift = bus_rdata >> {w_ld_lane, 3'b000};
        case (r_func3[1:0])
            2'b00:   w_ld_data = {{24{~r_func3[2] & w_ld_shift[7]}}, w_ld_shift[7:0]};
            2'b01:   w_ld_data = {{16{~r_func3[2] & w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: w_ld_data = bus_rdata;
        endcase
    end

    // NOTE: next-state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_resp_take || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every flop uses <= so all of them sample pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs are registered copies of the next state, so they track the state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lsu_ready     <= 1'b1;
            r_lsu_done      <= 1'b0;
            r_bus_req_valid <= 1'b0;
            r_wait_cnt      <= 8'd0;
        end else begin
            r_lsu_ready     <= (w_state_nxt == S_IDLE);
            r_lsu_done      <= (w_state_nxt == S_DONE);
            r_bus_req_valid <= (w_state_nxt == S_REQ);
            r_wait_cnt      <= (r_state == S_WAIT) ? w_cnt_inc : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_func3     <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= 4'b0000;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_we      <= mem_wen;
            r_func3   <= func3;
            r_addr_lo <= addr[1:0];
            if (w_misalign) begin
                r_bus_wstrb <= 4'b0000;
            end else begin
                r_bus_we    <= mem_wen;
                r_bus_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
                r_bus_wdata <= w_st_data;
                r_bus_wstrb <= mem_wen ? w_st_strb : 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lsu_err   <= 1'b0;
            r_lsu_rdata <= '0;
        end else if ((r_state == S_IDLE) && w_accept && w_misalign) begin
            r_lsu_err   <= 1'b1;
            r_lsu_rdata <= '0;
        end else if (w_resp_take) begin
            r_lsu_err   <= 1'b0;
            r_lsu_rdata <= r_we ? '0 : w_ld_data;
        end else if (w_timeout) begin
            r_lsu_err   <= 1'b1;
            r_lsu_rdata <= '0;
        end else if (r_state == S_DONE) begin
            r_lsu_err   <= 1'b0;
        end
    end

    assign lsu_ready     = r_lsu_ready;
    assign lsu_done      = r_lsu_done;
    assign lsu_err       = r_lsu_err;
    assign lsu_rdata     = r_lsu_rdata;
    assign bus_req_valid = r_bus_req_valid;
    assign bus_we        = r_bus_we;
    assign bus_addr      = r_bus_addr;
    assign bus_wdata     = r_bus_wdata;
    assign bus_wstrb     = r_bus_wstrb;

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// Self-checking bench for ysyx_24100012_lsu: directed cases plus randomized accesses checked
// against a byte-arithmetic model of lane steering, extension and response timing.
module tb_ysyx_24100012_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, mem_ren, mem_wen;
    logic [2:0]  func3;
    logic [31:0] addr, wdata;
    logic        lsu_ready, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24100012_lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .func3(func3), .addr(addr), .wdata(wdata),
        .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One complete access; stimulus changes and sampling both happen on the falling edge.
    task automatic do_access(input logic wen, input logic ren, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int ready_dly, input int resp_dly, input string tag);
        int          sz, off, exp_k, got_k;
        logic        mis, e_err;
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_rd, v, mask, e_addr;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = (sz == 1) ? int'(a % 4) : (sz == 2) ? int'((a % 4) / 2 * 2) : 0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
`else
        mis = 1'b0;
`endif
        e_addr = a - (a % 4);
        e_strb = wen ? 4'(((1 << sz) - 1) << off) : 4'b0000;
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v = (rd >> (8 * off)) & mask;
        if (sz < 4 && f3[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
        e_err = mis || (resp_dly >= TO);
        e_rd  = (wen || e_err) ? 32'h0 : v;
        exp_k = (resp_dly < TO) ? resp_dly + 1 : TO;

        n_tests++;
        if (lsu_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s idle_ready: got %b want 1", tag, lsu_ready);
        end
        lsu_valid = 1'b1; mem_ren = ren; mem_wen = wen; func3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        lsu_valid = 1'b0; addr = $urandom; wdata = $urandom; func3 = 3'($urandom);

        if (mis) begin
            n_tests++;
            if (bus_req_valid !== 1'b0 || bus_wstrb !== 4'b0000 || lsu_done !== 1'b1
                || lsu_err !== 1'b1 || lsu_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL %s trap: got req=%b strb=%b done=%b err=%b rdata=%h want 0 0000 1 1 0",
                         tag, bus_req_valid, bus_wstrb, lsu_done, lsu_err, lsu_rdata);
            end
        end else begin
            for (int c = 0; c <= ready_dly; c++) begin
                n_tests++;
                if (bus_req_valid !== 1'b1 || bus_addr !== e_addr || bus_we !== wen
                    || bus_wstrb !== e_strb || (wen && bus_wdata !== e_wd)
                    || lsu_ready !== 1'b0 || lsu_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s req[%0d]: got v=%b a=%h we=%b s=%b wd=%h rdy=%b dn=%b want 1 %h %b %b %h 0 0",
                             tag, c, bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
                             lsu_ready, lsu_done, e_addr, wen, e_strb, e_wd);
                end
                bus_req_ready = (c == ready_dly);
                @(negedge clk);
            end
            bus_req_ready = 1'b0;
            got_k = -1;
            for (int k = 0; k < 20; k++) begin
                if (lsu_done === 1'b1) begin
                    got_k = k;
                    break;
                end
                n_tests++;
                if (lsu_ready !== 1'b0 || bus_req_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s wait[%0d]: got ready=%b req=%b want 0 0",
                             tag, k, lsu_ready, bus_req_valid);
                end
                bus_resp_valid = (k == resp_dly);
                bus_rdata      = (k == resp_dly) ? rd : $urandom;
                @(negedge clk);
                bus_resp_valid = 1'b0;
            end
            n_tests++;
            if (got_k !== exp_k) begin
                n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", tag, got_k, exp_k);
            end
            n_tests++;
            if (lsu_err !== e_err || lsu_rdata !== e_rd) begin
                n_fail++;
                $display("FAIL %s result: got err=%b rdata=%h want err=%b rdata=%h",
                         tag, lsu_err, lsu_rdata, e_err, e_rd);
            end
        end
        @(negedge clk);
        n_tests++;
        if (lsu_done !== 1'b0 || lsu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b ready=%b want 0 1", tag, lsu_done, lsu_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (lsu_ready !== 1'b1 || lsu_done !== 1'b0 || lsu_err !== 1'b0 || lsu_rdata !== 32'h0
            || bus_req_valid !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0
            || bus_wdata !== 32'h0 || bus_wstrb !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b done=%b err=%b rdata=%h req=%b we=%b a=%h wd=%h s=%b",
                     lsu_ready, lsu_done, lsu_err, lsu_rdata, bus_req_valid, bus_we, bus_addr,
                     bus_wdata, bus_wstrb);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loads();
        do_access(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'h0, 32'h1234_5678, 0, 0, "lw");
        do_access(1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 0, 0, "lb");
        do_access(1'b0, 1'b1, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 0, 0, "lbu");
        do_access(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0, 32'h80FF_7F01, 0, 0, "lh");
        do_access(1'b0, 1'b1, 3'b101, 32'h8000_0002, 32'h0, 32'h80FF_7F01, 0, 0, "lhu");
        do_access(1'b0, 1'b1, 3'b000, 32'h8000_0000, 32'h0, 32'h80FF_7F01, 0, 0, "lb_lane0");
        do_access(1'b0, 1'b1, 3'b111, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 0, 0, "lw_f3_111");
    endtask

    task automatic test_stores();
        do_access(1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h5555_5555, 0, 0, "sb");
        do_access(1'b1, 1'b0, 3'b001, 32'h8000_0006, 32'h1234_BEEF, 32'h0, 1, 1, "sh");
        do_access(1'b1, 1'b1, 3'b010, 32'h8000_000C, 32'hA5A5_0FF0, 32'h0, 0, 0, "sw_both_en");
    endtask

    task automatic test_ignore();
        lsu_valid = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (lsu_ready !== 1'b1 || bus_req_valid !== 1'b0 || lsu_done !== 1'b0) begin
                n_fail++;
                $display("FAIL ignore_no_enable: got ready=%b req=%b done=%b want 1 0 0",
                         lsu_ready, bus_req_valid, lsu_done);
            end
        end
        lsu_valid = 1'b0;
        bus_resp_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (lsu_done !== 1'b0 || lsu_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_resp_ignored: got done=%b ready=%b want 0 1", lsu_done, lsu_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 3'b010, 32'h8000_0100, 32'h0, 32'h0BAD_CAFE, 5, 2, "ready_stall");
        do_access(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 100, "timeout");
        do_access(1'b0, 1'b1, 3'b001, 32'h8000_0012, 32'h0, 32'h8001_0000, 0, TO - 1, "resp_last_cycle");
    endtask

    task automatic test_reset_in_wait();
        lsu_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; func3 = 3'b010; addr = 32'h8000_0020;
        @(negedge clk);
        lsu_valid = 1'b0; bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (lsu_ready !== 1'b1 || bus_req_valid !== 1'b0 || lsu_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_wait: got ready=%b req=%b done=%b want 1 0 0",
                     lsu_ready, bus_req_valid, lsu_done);
        end
        bus_resp_valid = 1'b1; bus_rdata = 32'h1111_2222;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (lsu_done !== 1'b0) begin
                n_fail++; $display("FAIL late_resp_dropped[%0d]: got done=%b want 0", i, lsu_done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_misalign();
        do_access(1'b0, 1'b1, 3'b010, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 0, "lw_misalign");
        do_access(1'b1, 1'b0, 3'b001, 32'h8000_0003, 32'h0000_9876, 32'h0, 0, 0, "sh_misalign");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            do_access(op != 0, op != 1, 3'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1; lsu_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; func3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_loads();
        test_stores();
        test_ignore();
        test_back_to_back();
        test_reset_in_wait();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
